// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and the sync/blank bundle shared by the timing generator.
package vga_timing_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } vga_sync_t;

    // Syncs idle high and nothing is visible while the pipe is empty.
    localparam vga_sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

endpackage

// File: rtl/sync_delay_line.sv
// DEPTH-stage shift register for the hs/vs/blank bundle; every stage resets to the idle value.
module sync_delay_line
    import vga_timing_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic      vga_clk,
    input  logic      reset,
    input  vga_sync_t d,
    output vga_sync_t q
);

    vga_sync_t stage [DEPTH];

    // NOTE: every stage is reset so a mid-frame reset cannot replay a stale sync pulse.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            stage <= '{default: SYNC_IDLE};
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, hs/vs/blank decode, line/frame strobes, frame counter.
// Define VGA_SYNC_ALIGN_EN to delay hs/vs/blank by SYNC_DELAY cycles to match registered RGB.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FRONT    = H_FRONT_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BACK     = H_BACK_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FRONT    = V_FRONT_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BACK     = V_BACK_DEF,
    parameter int SYNC_DELAY = 1
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_timing
        $error("vga_timing_gen: H/V totals exceed the 10-bit counter range");
    end

    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [9:0] hc;
    logic [9:0] vc;
    logic       h_last;
    logic       v_last;
    vga_sync_t  sync_raw;
    vga_sync_t  sync_out;

    assign h_last = (hc == H_LAST);
    assign v_last = (vc == V_LAST);

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc          <= '0;
            vc          <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            // Strobes look one cycle ahead so they coincide with the (0,y) / (0,0) counter state.
            line_start  <= h_last;
            frame_start <= h_last && v_last;
            if (h_last) begin
                hc <= '0;
                vc <= v_last ? '0 : vc + 10'd1;
            end else begin
                hc <= hc + 10'd1;
            end
            if (h_last && v_last) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    assign sync_raw = '{
        hs:    !((hc >= HS_FIRST) && (hc <= HS_LAST)),
        vs:    !((vc >= VS_FIRST) && (vc <= VS_LAST)),
        blank: (hc < H_VIS) && (vc < V_VIS)
    };

`ifdef VGA_SYNC_ALIGN_EN
    if (SYNC_DELAY < 1 || SYNC_DELAY > 4) begin : g_bad_delay
        $error("vga_timing_gen: SYNC_DELAY must be in 1..4");
    end

    sync_delay_line #(
        .DEPTH(SYNC_DELAY)
    ) u_sync_delay (
        .vga_clk(vga_clk),
        .reset  (reset),
        .d      (sync_raw),
        .q      (sync_out)
    );
`else
    assign sync_out = sync_raw;
`endif

    assign DrawX = hc;
    assign DrawY = vc;
    assign hs    = sync_out.hs;
    assign vs    = sync_out.vs;
    assign blank = sync_out.blank;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a full-size instance for line timing and a tiny-timing instance for frame behaviour.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_ALIGN_EN
    localparam int   D         = 1;
    localparam logic BLANK_RST = 1'b0;
`else
    localparam int   D         = 0;
    localparam logic BLANK_RST = 1'b1;
`endif

    logic vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    logic        reset_d, reset_s;
    logic [9:0]  d_x, d_y, s_x, s_y;
    logic        d_blank, d_hs, d_vs, d_ls, d_fs;
    logic        s_blank, s_hs, s_vs, s_ls, s_fs;
    logic [15:0] d_fc, s_fc;

    int tests = 0;
    int fails = 0;
    int hs_low, vs_low, bl_hi, ls_cnt, fs_cnt, vblank_bad;

    vga_timing_gen #(.SYNC_DELAY(1)) dut_d (
        .vga_clk(vga_clk), .reset(reset_d), .DrawX(d_x), .DrawY(d_y), .blank(d_blank),
        .hs(d_hs), .vs(d_vs), .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
    );

    // Tiny raster: H 8+2+3+3 = 16, hs low at x 10..12; V 6+2+2+2 = 12, vs low at y 8..9.
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .SYNC_DELAY(1)
    ) dut_s (
        .vga_clk(vga_clk), .reset(reset_s), .DrawX(s_x), .DrawY(s_y), .blank(s_blank),
        .hs(s_hs), .vs(s_vs), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
    );

    task automatic step(input int n);
        repeat (n) @(negedge vga_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset_d = 1'b1;
        reset_s = 1'b1;
        step(3);
        check("rst_x", 32'(d_x), 0);
        check("rst_y", 32'(d_y), 0);
        check("rst_hs", 32'(d_hs), 1);
        check("rst_vs", 32'(d_vs), 1);
        check("rst_blank", 32'(d_blank), 32'(BLANK_RST));
        check("rst_ls", 32'(d_ls), 0);
        check("rst_fs", 32'(d_fs), 0);
        check("rst_fc", 32'(d_fc), 0);

        // Full-size raster, line 0 and line 1.
        reset_d = 1'b0;
        check("blank_first", 32'(d_blank), 32'(BLANK_RST));
        step(639 + D);
        check("x_639d", 32'(d_x), 32'(639 + D));
        check("blank_last_vis", 32'(d_blank), 1);
        step(1);
        check("blank_fall", 32'(d_blank), 0);
        step(15);
        check("hs_pre", 32'(d_hs), 1);
        step(1);
        check("hs_fall_x", 32'(d_x), 32'(656 + D));
        check("hs_fall", 32'(d_hs), 0);
        step(95);
        check("hs_last_low", 32'(d_hs), 0);
        step(1);
        check("hs_rise", 32'(d_hs), 1);
        step(47 - D);
        check("x_799", 32'(d_x), 799);
        check("y_line0", 32'(d_y), 0);
        check("ls_before_wrap", 32'(d_ls), 0);
        step(1);
        check("wrap_x", 32'(d_x), 0);
        check("wrap_y", 32'(d_y), 1);
        check("wrap_ls", 32'(d_ls), 1);
        check("wrap_fs", 32'(d_fs), 0);

        hs_low = 0; bl_hi = 0; ls_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            step(1);
            if (!d_hs) hs_low++;
            if (d_blank) bl_hi++;
            if (d_ls) ls_cnt++;
        end
        check("line_hs_low", 32'(hs_low), 96);
        check("line_blank_hi", 32'(bl_hi), 640);
        check("line_ls_cnt", 32'(ls_cnt), 1);
        check("line2_y", 32'(d_y), 2);

        // Reset in the middle of an hs pulse.
        step(700);
        check("pre_rst_hs", 32'(d_hs), 0);
        reset_d = 1'b1;
        step(1);
        check("midrst_x", 32'(d_x), 0);
        check("midrst_y", 32'(d_y), 0);
        check("midrst_hs", 32'(d_hs), 1);
        check("midrst_vs", 32'(d_vs), 1);
        check("midrst_fs", 32'(d_fs), 0);
        check("midrst_fc", 32'(d_fc), 0);

        // Tiny raster: frame period 192 cycles.
        reset_s = 1'b0;
        step(191);
        check("s_x_last", 32'(s_x), 15);
        check("s_y_last", 32'(s_y), 11);
        check("s_fs_none", 32'(s_fs), 0);
        check("s_fc0", 32'(s_fc), 0);
        step(1);
        check("s_frame_x", 32'(s_x), 0);
        check("s_frame_y", 32'(s_y), 0);
        check("s_frame_fs", 32'(s_fs), 1);
        check("s_frame_ls", 32'(s_ls), 1);
        check("s_frame_fc", 32'(s_fc), 1);

        hs_low = 0; vs_low = 0; bl_hi = 0; ls_cnt = 0; fs_cnt = 0; vblank_bad = 0;
        for (int i = 0; i < 192; i++) begin
            step(1);
            if (!s_hs) hs_low++;
            if (!s_vs) vs_low++;
            if (s_blank) bl_hi++;
            if (s_ls) ls_cnt++;
            if (s_fs) fs_cnt++;
            if (s_y >= 10'd6 && s_blank) vblank_bad++;
        end
        check("s_hs_low", 32'(hs_low), 36);
        check("s_vs_low", 32'(vs_low), 32);
        check("s_blank_hi", 32'(bl_hi), 48);
        check("s_ls_cnt", 32'(ls_cnt), 12);
        check("s_fs_cnt", 32'(fs_cnt), 1);
        check("s_vblank", 32'(vblank_bad), 0);
        check("s_fc2", 32'(s_fc), 2);

        step(117);
        check("s_vs_y7", 32'(s_vs), 1);
        step(32);
        check("s_y9", 32'(s_y), 9);
        check("s_vs_y9", 32'(s_vs), 0);
        step(16);
        check("s_vs_y10", 32'(s_vs), 1);

        // Jump frame_count to its wrap point just before a frame boundary.
        step(26);
        check("s_pre_wrap_x", 32'(s_x), 15);
        force dut_s.frame_count = 16'hFFFF;
        #1;
        release dut_s.frame_count;
        check("s_fc_ffff", 32'(s_fc), 32'hFFFF);
        step(1);
        check("s_fc_wrap", 32'(s_fc), 0);
        check("s_fs_wrap", 32'(s_fs), 1);

        // Reset mid-frame during an hs pulse.
        step(91);
        check("s_mid_y", 32'(s_y), 5);
        check("s_mid_hs", 32'(s_hs), 0);
        reset_s = 1'b1;
        step(1);
        check("s_rst_x", 32'(s_x), 0);
        check("s_rst_y", 32'(s_y), 0);
        check("s_rst_hs", 32'(s_hs), 1);
        check("s_rst_vs", 32'(s_vs), 1);
        check("s_rst_blank", 32'(s_blank), 32'(BLANK_RST));
        check("s_rst_fs", 32'(s_fs), 0);
        check("s_rst_ls", 32'(s_ls), 0);
        check("s_rst_fc", 32'(s_fc), 0);
        reset_s = 1'b0;
        step(1);
        check("s_post_x", 32'(s_x), 1);
        check("s_post_ls", 32'(s_ls), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
